// File: rtl/wide_addsub_pkg.sv
// -----------------------------------------------------------------------------
// wide_addsub_pkg
// Shared definitions for the byte-serial wide add/subtract sequencer:
//   SLICE_W      - width of the single carry-lookahead slice (8 bits)
//   state_e      - sequencer FSM state encoding
//   add_overflow - two's-complement overflow from the MSB bits of the top slice
// -----------------------------------------------------------------------------
package wide_addsub_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed overflow: the operands seen by the adder (A and the possibly
    // inverted B) agree in sign, but the result sign differs from them.
    function automatic logic add_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic sub,
                                          input logic sum_msb);
        logic beff_msb;
        beff_msb = b_msb ^ sub;
        return (a_msb == beff_msb) && (sum_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_08.sv
// -----------------------------------------------------------------------------
// cla_08
// Purely combinational 8-bit carry-lookahead add/subtract slice.
// Computes sum = src1 + (src2 ^ {8{sub_flag}}) + carry_in.
// Ports:
//   src1      in  [7:0]  first operand
//   src2      in  [7:0]  second operand (inverted when sub_flag = 1)
//   sub_flag  in         selects inversion of src2
//   carry_in  in         carry into bit 0
//   sum       out [7:0]  slice sum
//   carry_out out        carry out of bit 7
// -----------------------------------------------------------------------------
module cla_08
    import wide_addsub_pkg::*;
(
    input  logic [SLICE_W-1:0] src1,
    input  logic [SLICE_W-1:0] src2,
    input  logic               sub_flag,
    input  logic               carry_in,
    output logic [SLICE_W-1:0] sum,
    output logic               carry_out
);

    logic [SLICE_W-1:0] b_eff;
    logic [SLICE_W-1:0] gen;
    logic [SLICE_W-1:0] prop;
    logic [SLICE_W:0]   carry;
    logic               group_gen;
    logic               group_prop;

    always_comb begin
        b_eff      = src2 ^ {SLICE_W{sub_flag}};
        gen        = src1 & b_eff;
        prop       = src1 ^ b_eff;
        carry      = '0;
        carry[0]   = carry_in;
        group_gen  = 1'b0;
        group_prop = 1'b0;
        // Each carry is formed directly from generate/propagate terms of all
        // lower bits (lookahead), not from the previous carry.
        for (int i = 0; i < SLICE_W; i++) begin
            group_gen  = gen[i];
            group_prop = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                group_gen  = group_gen | (group_prop & gen[j]);
                group_prop = group_prop & prop[j];
            end
            carry[i+1] = group_gen | (group_prop & carry_in);
        end
        sum       = prop ^ carry[SLICE_W-1:0];
        carry_out = carry[SLICE_W];
    end

endmodule

// File: rtl/wide_addsub_seq.sv
// -----------------------------------------------------------------------------
// wide_addsub_seq
// W-bit (W = 8*WORDS) add/subtract performed one byte per cycle, LSB first,
// through a single cla_08 slice. Operands are captured on accept, shifted
// right a byte per RUN cycle, and the slice sums are shifted into the result
// register from the top so the full result is aligned after WORDS cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   in_a, in_b, in_sub    operands and operation select (1 = A-B)
//   out_valid / out_ready result handshake
//   out_sum               result modulo 2^W
//   out_carry             carry out of MSB slice (subtract: 1 = no borrow)
//   out_overflow          two's-complement overflow
//   busy                  transaction in flight or result pending
// -----------------------------------------------------------------------------
module wide_addsub_seq
    import wide_addsub_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SLICE_W*WORDS-1:0] in_a,
    input  logic [SLICE_W*WORDS-1:0] in_b,
    input  logic                     in_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SLICE_W*WORDS-1:0] out_sum,
    output logic                     out_carry,
    output logic                     out_overflow,
    output logic                     busy
);

    localparam int W     = SLICE_W * WORDS;
    localparam int CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(WORDS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               sub_q, sub_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_q, res_d;
    logic               out_carry_q, out_carry_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               slice_cin;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // The first slice takes the subtract "+1" as its carry-in.
    assign slice_cin = (cnt_q == '0) ? sub_q : carry_q;

    cla_08 u_slice (
        .src1      (a_q[SLICE_W-1:0]),
        .src2      (b_q[SLICE_W-1:0]),
        .sub_flag  (sub_q),
        .carry_in  (slice_cin),
        .sum       (slice_sum),
        .carry_out (slice_cout)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        sub_d       = sub_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        out_carry_d = out_carry_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = in_sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {slice_sum, res_q[W-1:SLICE_W]};
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                carry_d = slice_cout;
                if (cnt_q == LAST_SLICE) begin
                    // Counter holds on the last slice; it is cleared on accept.
                    out_carry_d = slice_cout;
                    ovf_d       = add_overflow(a_q[SLICE_W-1], b_q[SLICE_W-1],
                                               sub_q, slice_sum[SLICE_W-1]);
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake flags are registered from the next state so no
        // combinational path reaches the outputs.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            sub_q       <= 1'b0;
            res_q       <= '0;
            out_carry_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            sub_q       <= sub_d;
            res_q       <= res_d;
            out_carry_q <= out_carry_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Operand shift registers are pure data: always reloaded on accept.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign busy         = busy_q;
    assign out_sum      = res_q;
    assign out_carry    = out_carry_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_addsub_seq
// Self-checking bench for wide_addsub_seq with WORDS = 4 (32-bit operands).
// Directed corner cases followed by randomized operations, each checked
// against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_wide_addsub_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         out_overflow;
    logic         busy;

    int n_cmp;
    int n_err;

    wide_addsub_seq #(.WORDS(WORDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain signed/unsigned integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] sum, output logic carry, output logic ovf);
        longint sa, sb, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        r  = sub ? (sa - sb) : (sa + sb);
        ovf   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        sum   = sub ? W'(ua - ub) : W'(ua + ub);
        carry = sub ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int hold, input bit early);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           cyc;
        model(a, b, sub, es, ec, eo);
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = early;
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_sub   = ~sub;
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 64'(cyc), 64'(WORDS + 1));
        check("sum", 64'(out_sum), 64'(es));
        check("carry", 64'(out_carry), 64'(ec));
        check("overflow", 64'(out_overflow), 64'(eo));
        check("busy_done", 64'(busy), 64'd1);
        check("in_ready_done", 64'(in_ready), 64'd0);
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                // A competing request while the result is pending must be ignored.
                in_valid = 1'b1;
                in_a     = $urandom;
                in_b     = $urandom;
                @(negedge clk);
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_sum", 64'(out_sum), 64'(es));
                check("hold_carry", 64'(out_carry), 64'(ec));
                check("hold_ovf", 64'(out_overflow), 64'(eo));
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_after_hs", 64'(out_valid), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(out_sum), 64'd0);
        check("rst_carry", 64'(out_carry), 64'd0);
        check("rst_ovf", 64'(out_overflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed corner cases
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b0);
        check("byte_carry_sum", 64'(out_sum), 64'h0000_0100);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        check("wrap_sum", 64'(out_sum), 64'd0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
        check("ovf_add", 64'(out_overflow), 64'd1);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0);
        check("ovf_sub", 64'(out_overflow), 64'd1);
        run_op(32'd5, 32'd7, 1'b1, 0, 1'b0);
        check("borrow_sum", 64'(out_sum), 64'hFFFF_FFFE);

        // Backpressure: result held for 10 cycles with competing requests
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 10, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h0000_1111, 1'b1, 0, 1'b1);

        // Reset in the middle of RUN
        while (!in_ready) @(negedge clk);
        in_a     = 32'hFFFF_FFFF;
        in_b     = 32'h0000_0001;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_sum", 64'(out_sum), 64'd0);
        check("midrst_carry", 64'(out_carry), 64'd0);
        check("midrst_ovf", 64'(out_overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd1, 32'd2, 1'b0, 0, 1'b0);
        check("after_rst_sum", 64'(out_sum), 64'd3);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            bit           re;
            int           rh;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                2: ra = 32'h7FFF_FFFF;
                3: rb = ra;
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            rh = re ? 0 : $urandom_range(0, 3);
            run_op(ra, rb, rs, rh, re);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wide_addsub_seq.md
# wide_addsub_seq

Multi-cycle sequencer that performs W-bit add/subtract (W = 8·WORDS) by time-multiplexing a single 8-bit carry-lookahead slice (`cla_08`), one byte per cycle, LSB first. It owns operand capture, carry chaining between cycles, result assembly and a valid/ready handshake on both sides. It sits between an operand producer (ALU issue logic or a test driver) and a result consumer, and trades latency for area against a fully unrolled wide CLA.

## Interface
Parameters:
- `WORDS`, default 4. Number of 8-bit slices; W = 8·WORDS. Legal range is 2..16.

Ports:
- `clk`, input, 1. Single clock; all state changes on the rising edge.
- `rst_n`, input, 1. Asynchronous, active-low reset.
- `in_valid`, input, 1. Operand request.
- `in_ready`, output, 1. Block can accept a request.
- `in_a`, input, W. Minuend/addend.
- `in_b`, input, W. Subtrahend/addend.
- `in_sub`, input, 1. 1 selects A−B; 0 selects A+B.
- `out_valid`, output, 1. Result available.
- `out_ready`, input, 1. Consumer accepts the result.
- `out_sum`, output, W. Result, modulo 2^W.
- `out_carry`, output, 1. Raw carry out of the MSB slice. For subtract, 1 means no borrow.
- `out_overflow`, output, 1. Two's-complement signed overflow.
- `busy`, output, 1. High in RUN or DONE.

## Operation
- **Slice contract.** The `cla_08` slice computes `src1 + (src2 ^ {8{sub_flag}}) + carry_in`.
  - `sub_flag` = latched `in_sub`.
  - First slice uses `carry_in` = latched `in_sub`.
  - Each later slice uses `carry_in` = the registered `carry_out` of the previous slice.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE.**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch A, B and sub, clear the slice counter, and go to RUN.
- **RUN.** Each cycle:
  - Feed A[7:0] and B[7:0] of the operand shift registers to the slice.
  - Shift the 8-bit slice sum into the result register from the top.
  - Shift A and B right by 8.
  - Register `carry_out`.
  - Increment the counter.
  - After slice WORDS−1, go to DONE.
- **Overflow.**
  - Computed on the final slice as `(a_msb == beff_msb) && (sum_msb != a_msb)`, where `beff_msb = b_msb ^ sub`.
  - Latched with the result.
- **DONE.**
  - `out_valid` = 1.
  - `out_sum`, `out_carry` and `out_overflow` are held stable until `out_valid && out_ready`, then the FSM goes to IDLE.
- **Backpressure.** In RUN and DONE, `in_ready` = 0. Inputs are ignored and do not corrupt latched operands.
- **Slice counter.** Width is `$clog2(WORDS)`. It does not wrap within a transaction and is cleared on every accept.
- **Reset.** Asserting `rst_n` low at any time, including mid-RUN, forces:
  - state IDLE;
  - `out_valid` = 0, `busy` = 0, `in_ready` = 0 while reset is asserted, then 1 after release;
  - `out_sum` = 0, `out_carry` = 0, `out_overflow` = 0;
  - counter and carry register = 0.
  
  An interrupted transaction is discarded, with no partial result.

## Timing
- Request accepted at rising edge T.
- RUN slices are processed on edges T+1 through T+WORDS.
- `out_valid` rises after edge T+WORDS, so latency is WORDS+1 cycles from accept to `out_valid`.
- Earliest re-accept: the edge after the output handshake, so throughput is one op per WORDS+2 cycles with `out_ready` tied high.
- Asserting `out_ready` before `out_valid` has no effect.
- `in_valid` may drop without being accepted; there is no requirement for it to stay high.
- All outputs are registered. No combinational path exists from `in_*` to `out_*`, or from `out_ready` to `in_ready`.

## Structure
- **Shared package `wide_addsub_pkg`:**
  - `SLICE_W` = 8.
  - FSM state enum: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
- **Sub-module:** exactly one `cla_08` instance as the slice datapath. The controller, shift registers and handshake live in `wide_addsub_seq`.

## Test plan
All scenarios use WORDS = 4.
- **Byte carry:** A=0x0000_00FF, B=0x0000_0001, add → sum 0x0000_0100, carry 0, overflow 0, `out_valid` exactly 5 cycles after accept.
- **Full wrap:** A=0xFFFF_FFFF, B=0x0000_0001, add → sum 0x0000_0000, carry 1, overflow 0.
- **Signed overflow:**
  - A=0x7FFF_FFFF + 0x0000_0001 → sum 0x8000_0000, overflow 1.
  - A=0x8000_0000 − 0x0000_0001 → sum 0x7FFF_FFFF, overflow 1, carry 1.
- **Subtract with borrow:** A=5, B=7, sub → sum 0xFFFF_FFFE, carry 0, overflow 0.
- **Backpressure:** hold `out_ready` = 0 for 10 cycles after `out_valid` → result stable, `in_ready` = 0 throughout. A new `in_valid` with different operands is ignored; the result is accepted on the first `out_ready`.
- **Reset mid-RUN:** pulse `rst_n` low for 1 cycle at slice 2 → all outputs zero, IDLE. A next request A=1, B=2, add produces 0x0000_0003 with no stale carry.
